// File: rtl/rgb2yuv_arb.sv
// rgb2yuv_arb
// Round-robin burst arbiter sharing one rgb2yuv converter (1-cycle latency)
// between two RGB pixel requesters. Accepted pixels are issued to the
// converter and tagged with {id, last}. The tag rides a 2-stage shift
// register alongside the converter. Results land in a credit-protected output
// FIFO that feeds a valid/ready YUV stream.
//
// Parameters:
//   BURST      - max pixels accepted per grant (1..65535)
//   FIFO_DEPTH - output FIFO entries (power of two, >= 4)
//
// Ports:
//   clk                       rising-edge clock
//   rst                       asynchronous reset, ACTIVE-LOW
//   req0_valid/ready/rgb      requester 0 pixel stream, rgb = {R,G,B}
//   req1_valid/ready/rgb      requester 1 pixel stream
//   cvt_valid, cvt_R/G/B      to converter
//   cvt_Y/U/V, cvt_outvalid   from converter
//   out_valid/ready           output handshake
//   out_yuv                   {Y,U,V}
//   out_id                    requester the pixel came from
//   out_last                  pixel closed a count-terminated burst
//
// Optional feature: define RGB2YUV_ARB_STATS_EN to add the stat0_pix,
// stat1_pix and stat_stall counter outputs.

module rgb2yuv_arb #(
  parameter int BURST      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_rgb,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_rgb,
  output logic        cvt_valid,
  output logic [7:0]  cvt_R,
  output logic [7:0]  cvt_G,
  output logic [7:0]  cvt_B,
  input  logic [7:0]  cvt_Y,
  input  logic [7:0]  cvt_U,
  input  logic [7:0]  cvt_V,
  input  logic        cvt_outvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_yuv,
  output logic        out_id,
  output logic        out_last
`ifdef RGB2YUV_ARB_STATS_EN
  ,
  output logic [31:0] stat0_pix,
  output logic [31:0] stat1_pix,
  output logic [31:0] stat_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg, last_grant_next;
  logic [15:0] burst_cnt_reg, burst_cnt_next;

  logic        sel_id;
  logic        sel_valid;
  logic [23:0] sel_rgb;
  logic        accept;
  logic        acc_last;
  logic        burst_done;
  logic        credit_ok;

  // Tag pipeline: stage 0 is aligned with cvt_valid, stage 1 with cvt_outvalid.
  logic        tag0_id_reg, tag0_last_reg;
  logic        tag1_valid_reg, tag1_id_reg, tag1_last_reg;

  logic [25:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   fifo_count_reg;
  logic [AW+1:0] occupancy;
  logic          wr_en, rd_en;
  logic [25:0]   wr_data;

  assign sel_id     = (state_reg == GRANT1);
  assign sel_valid  = sel_id ? req1_valid : req0_valid;
  assign sel_rgb    = sel_id ? req1_rgb : req0_rgb;
  assign burst_done = (({1'b0, burst_cnt_reg} + 17'd1) == 17'(BURST));

  // The converter cannot be stalled, so every pixel already in the tag
  // pipeline must have a FIFO slot reserved before another is accepted.
  assign occupancy = {1'b0, fifo_count_reg}
                   + (AW+2)'(cvt_valid)
                   + (AW+2)'(tag1_valid_reg);
  assign credit_ok = (occupancy < (AW+2)'(FIFO_DEPTH));

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    accept          = 1'b0;
    acc_last        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // Contention: the requester that did not win last time goes next.
          state_next      = last_grant_reg ? GRANT0 : GRANT1;
          last_grant_next = ~last_grant_reg;
          burst_cnt_next  = '0;
        end else if (req0_valid) begin
          state_next      = GRANT0;
          last_grant_next = 1'b0;
          burst_cnt_next  = '0;
        end else if (req1_valid) begin
          state_next      = GRANT1;
          last_grant_next = 1'b1;
          burst_cnt_next  = '0;
        end
      end
      GRANT0, GRANT1: begin
        req0_ready = ~sel_id & credit_ok;
        req1_ready = sel_id & credit_ok;
        if (!sel_valid) begin
          state_next = IDLE;
        end else if (credit_ok) begin
          accept         = 1'b1;
          burst_cnt_next = burst_cnt_reg + 16'd1;
          if (burst_done) begin
            acc_last   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

  // Converter issue stage and tag pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cvt_valid      <= 1'b0;
      cvt_R          <= '0;
      cvt_G          <= '0;
      cvt_B          <= '0;
      tag0_id_reg    <= 1'b0;
      tag0_last_reg  <= 1'b0;
      tag1_valid_reg <= 1'b0;
      tag1_id_reg    <= 1'b0;
      tag1_last_reg  <= 1'b0;
    end else begin
      cvt_valid <= accept;
      if (accept) begin
        cvt_R         <= sel_rgb[23:16];
        cvt_G         <= sel_rgb[15:8];
        cvt_B         <= sel_rgb[7:0];
        tag0_id_reg   <= sel_id;
        tag0_last_reg <= acc_last;
      end
      tag1_valid_reg <= cvt_valid;
      tag1_id_reg    <= tag0_id_reg;
      tag1_last_reg  <= tag0_last_reg;
    end
  end

  // Output FIFO. A converter result without a matching tag is discarded.
  assign wr_en   = cvt_outvalid & tag1_valid_reg;
  assign rd_en   = out_valid & out_ready;
  assign wr_data = {cvt_Y, cvt_U, cvt_V, tag1_id_reg, tag1_last_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_count_reg <= fifo_count_reg + (AW+1)'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - (AW+1)'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Head entry drives the outputs directly, so they stay put under backpressure.
  assign out_valid = (fifo_count_reg != '0);
  assign {out_yuv, out_id, out_last} = fifo_mem[rd_ptr_reg];

`ifdef RGB2YUV_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat0_pix  <= '0;
      stat1_pix  <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && !sel_id)         stat0_pix  <= stat0_pix + 32'd1;
      if (accept && sel_id)          stat1_pix  <= stat1_pix + 32'd1;
      if (out_valid && !out_ready)   stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb2yuv_arb.sv
// Testbench for rgb2yuv_arb: models the rgb2yuv converter (1-cycle latency),
// drives directed and random requester traffic, and checks the YUV output
// stream against a scoreboard filled from accepted pixels.

module tb_rgb2yuv_arb;

  localparam int BURST = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_rgb, req1_rgb;
  logic        cvt_valid;
  logic [7:0]  cvt_R, cvt_G, cvt_B;
  logic [7:0]  cvt_Y, cvt_U, cvt_V;
  logic        cvt_outvalid;
  logic        out_valid, out_ready;
  logic [23:0] out_yuv;
  logic        out_id, out_last;
`ifdef RGB2YUV_ARB_STATS_EN
  logic [31:0] stat0_pix, stat1_pix, stat_stall;
`endif

  rgb2yuv_arb #(.BURST(BURST), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rgb(req0_rgb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rgb(req1_rgb),
    .cvt_valid(cvt_valid), .cvt_R(cvt_R), .cvt_G(cvt_G), .cvt_B(cvt_B),
    .cvt_Y(cvt_Y), .cvt_U(cvt_U), .cvt_V(cvt_V), .cvt_outvalid(cvt_outvalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_yuv(out_yuv),
    .out_id(out_id), .out_last(out_last)
`ifdef RGB2YUV_ARB_STATS_EN
    , .stat0_pix(stat0_pix), .stat1_pix(stat1_pix), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // BT.601 studio-swing integer conversion.
  function automatic logic [23:0] to_yuv(input logic [23:0] rgb);
    int r, g, b, y, u, v;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    y = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16;
    u = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128;
    v = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128;
    return {y[7:0], u[7:0], v[7:0]};
  endfunction

  // Converter model.
  always @(posedge clk) begin
    cvt_outvalid <= cvt_valid;
    {cvt_Y, cvt_U, cvt_V} <= to_yuv({cvt_R, cvt_G, cvt_B});
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [23:0] yuv;
    logic        id;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: per-requester run length within the current burst.
  bit [1:0] broken = 2'b11;
  int       run[2] = '{0, 0};
  int       pix_cnt[2] = '{0, 0};
  int       stalls = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted pixel pushes its expected
  // output. A burst restarts whenever the requester went invalid or the other
  // requester was served since its previous pixel.
  initial begin
    logic a0, a1, id;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        if (a0 || a1) begin
          checks++;
          if (a0 && a1) begin
            fails++;
            $display("FAIL dual_accept: got both readies expected one");
          end
          id = a1;
          if (broken[id]) run[id] = 0;
          broken[id] = 1'b0;
          run[id]++;
          e.yuv  = to_yuv(id ? req1_rgb : req0_rgb);
          e.id   = id;
          e.last = (run[id] == BURST);
          if (e.last) broken[id] = 1'b1;
          broken[!id] = 1'b1;
          pix_cnt[id]++;
          exp_q.push_back(e);
        end
        if (!req0_valid) broken[0] = 1'b1;
        if (!req1_valid) broken[1] = 1'b1;
        if (out_valid && !out_ready) stalls++;
      end
    end
  end

  // Monitor: output head must match scoreboard head whenever valid.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got yuv %h id %0d with nothing pending", out_yuv, out_id);
        end else begin
          if ({out_yuv, out_id, out_last} !== exp_q[0]) begin
            fails++;
            $display("FAIL out_word: got yuv %h id %0d last %0d expected yuv %h id %0d last %0d",
                     out_yuv, out_id, out_last, exp_q[0].yuv, exp_q[0].id, exp_q[0].last);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && !cvt_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int ids[$], cycs[$];
    int n, t0, t1, got;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rgb = '0; req1_rgb = '0;
    out_ready = 1'b0;
    #2;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_cvt_valid", cvt_valid, 0);
    check("rst_cvt_rgb", {cvt_R, cvt_G, cvt_B}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", {out_yuv, out_id, out_last}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Both requesters continuously valid: alternating bursts of BURST.
    out_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req0_rgb = $urandom; req1_rgb = $urandom;
      @(negedge clk);
      if (req0_valid && req0_ready) begin ids.push_back(0); cycs.push_back(cyc); end
      if (req1_valid && req1_ready) begin ids.push_back(1); cycs.push_back(cyc); end
      @(posedge clk); #1;
    end
    check("alt_accept_count_ge12", ids.size() >= 12, 1);
    for (int k = 0; k < 12 && k < ids.size(); k++) begin
      check($sformatf("alt_id_%0d", k), ids[k], (k / BURST) % 2);
      if (k > 0) check($sformatf("alt_gap_%0d", k), cycs[k] - cycs[k-1], (k % BURST == 0) ? 2 : 1);
    end
    drain();

    // Single white pixel from requester 0: value and 3-cycle latency.
    req0_rgb = 24'hFFFFFF;
    req0_valid = 1'b1;
    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin t0 = cyc; break; end
      @(posedge clk); #1;
    end
    check("white_accepted", t0 >= 0, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    t1 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin t1 = cyc; break; end
    end
    check("white_latency", t1 - t0, 3);
    check("white_yuv", out_yuv, 24'hEB8080);
    check("white_id", out_id, 0);
    check("white_last", out_last, 0);
    drain();

    // Requester 1 against a stalled output: credits cap acceptance at DEPTH.
    out_ready = 1'b0;
    req1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      req1_rgb = $urandom;
      @(negedge clk);
      if (req1_valid && req1_ready) n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("credit_accepts", n, DEPTH);
    check("credit_ready_low", req1_ready, 0);
    drain();

    // Requester 0 drops valid after 2 pixels; pending requester 1 follows.
    req0_valid = 1'b1;
    n = 0; t0 = 0;
    for (int i = 0; i < 30; i++) begin
      req0_rgb = $urandom; req1_rgb = $urandom;
      @(negedge clk);
      if (req0_valid && req0_ready) begin n++; t0 = cyc; end
      if (n == 2) break;
      @(posedge clk); #1;
      req1_valid = 1'b1;
    end
    check("drop_req0_accepts", n, 2);
    @(posedge clk); #1 req0_valid = 1'b0;
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) begin t1 = cyc; break; end
      @(posedge clk); #1;
    end
    check("drop_req1_grant_delay", t1 - t0, 3);
    drain();

    // Reset with 3 pixels in flight.
    out_ready = 1'b0;
    req0_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      req0_rgb = $urandom;
      @(negedge clk);
      if (req0_valid && req0_ready) n++;
      if (n == 3) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cvt_valid", cvt_valid, 0);
    check("midrst_ready", {req0_ready, req1_ready}, 0);
    check("midrst_out_word", {out_yuv, out_id, out_last}, 0);
    exp_q.delete();
    broken = 2'b11; run = '{0, 0}; pix_cnt = '{0, 0}; stalls = 0;
    req1_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    got = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("postrst_no_stale", out_valid, 0);
      if (req0_valid && req0_ready) begin got = 0; break; end
      if (req1_valid && req1_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("postrst_first_grant", got, 0);
    repeat (12) @(posedge clk);
    drain();

    // Random soak with random backpressure.
    for (int i = 0; i < 500; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_rgb = $urandom; req1_rgb = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();
    check("final_queue_empty", exp_q.size(), 0);
`ifdef RGB2YUV_ARB_STATS_EN
    check("stat0_pix", stat0_pix, pix_cnt[0]);
    check("stat1_pix", stat1_pix, pix_cnt[1]);
    check("stat_stall", stat_stall, stalls);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rgb2yuv_arb.md
# rgb2yuv_arb

Round-robin burst arbiter that shares one `rgb2yuv` converter instance between two RGB pixel requesters. It drives the converter's `valid`/`R`/`G`/`B` inputs and tracks the owner of each in-flight pixel. It collects converter results into a credit-managed output FIFO, and emits a tagged YUV stream with valid/ready backpressure. It sits between the two capture/DMA pixel sources and the downstream YUV consumer.

## Interface
- `BURST`, 64: maximum pixels accepted per grant before arbitration is re-run; range 1..65535.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, minimum 4.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req0_valid` / `req1_valid` in 1: requester pixel valid.
- `req0_ready` / `req1_ready` out 1: requester pixel accepted when valid and ready are both high.
- `req0_rgb` / `req1_rgb` in 24: {R[23:16], G[15:8], B[7:0]}.
- `cvt_valid` out 1: to converter `valid`.
- `cvt_R` / `cvt_G` / `cvt_B` out 8 each: to converter R/G/B.
- `cvt_Y` / `cvt_U` / `cvt_V` in 8 each: from converter.
- `cvt_outvalid` in 1: from converter `outvalid`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accept.
- `out_yuv` out 24: {Y, U, V}.
- `out_id` out 1: source requester of `out_yuv`.
- `out_last` out 1: pixel is the last of its burst.

## Operation
- States: IDLE, GRANT0, GRANT1. A 1-bit `last_grant` register resets to 1, so requester 0 wins the first arbitration.
- IDLE: if both valids are high, grant the requester not equal to `last_grant`; else grant whichever valid is high; else stay. Entering GRANTn sets `last_grant` = n and clears the burst counter.
- GRANTn: `reqn_ready` = `credit_ok`; the other requester's ready is 0. Each accept increments the 16-bit burst counter.
- A burst ends on the accept that brings the count to `BURST`, or in any GRANTn cycle where `reqn_valid` = 0. The next state is IDLE in both cases, which costs one bubble cycle between bursts.
- An accepted pixel is registered onto `cvt_valid`/`cvt_R`/`cvt_G`/`cvt_B` for exactly one cycle, along with the tag {id, last}. `last` is 1 only for a count-terminated burst.
- The tag travels through a 2-stage shift register aligned with the converter's 1-cycle latency. On `cvt_outvalid`, {Y, U, V, id, last} is written into the FIFO.
- Credits: `credit_ok` = (fifo_count + inflight) < `FIFO_DEPTH`, where inflight counts the set tag-stage valids (0..2). This rule guarantees the FIFO never overflows, because the converter cannot be stalled.
- If `cvt_outvalid` arrives with no matching tag-stage valid, the result is dropped. This cannot occur with a correctly connected converter.
- FIFO: simultaneous write and read are allowed, including when the FIFO is full and `out_ready` is high. The read pointer advances when `out_valid && out_ready`.

## Timing
- Reset values: all readies 0, `cvt_valid` 0, `cvt_R`/`cvt_G`/`cvt_B` 0, `out_valid` 0, `out_yuv` 0, `out_id` 0, `out_last` 0. State resets to IDLE, FIFO and tag stages are empty, and counters are 0.
- Accept at edge E gives `cvt_valid` in cycle E+1, then converter `outvalid` in E+2, then FIFO write at edge E+3. `out_valid` is high from cycle E+3, so accept-to-output latency is 3 cycles with an empty FIFO.
- Sustained throughput is 1 pixel/cycle within a burst when `out_ready` is held high.
- Arbitration latency: the first `reqn_ready` comes 1 cycle after `reqn_valid` is seen in IDLE.
- Asserting reset mid-burst drops in-flight and FIFO contents. After release, the block restarts in IDLE with `last_grant` = 1.
- `out_yuv`/`out_id`/`out_last` hold stable while `out_valid && !out_ready`.

## Configuration
- `RGB2YUV_ARB_STATS_EN` defined adds the following output ports:
  - `stat0_pix` and `stat1_pix`, 32-bit each: accepted-pixel counts per requester, wrapping at 2^32.
  - `stat_stall`, 32-bit: cycles with `out_valid && !out_ready`.
  - All three counters reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Requester 0 only, RGB (255,255,255), `out_ready` = 1 → `out_yuv` = {0xEB,0x80,0x80} (Y235, U128, V128), `out_id` 0, first output 3 cycles after accept.
- Both requesters continuously valid, `BURST` = 4 → grants alternate 4 from requester 0, then 4 from requester 1, and so on. `out_id` pattern is 0000 1111 with `out_last` high on every 4th pixel, and exactly one idle cycle between bursts.
- Requester 1 streams while `out_ready` = 0 → exactly `FIFO_DEPTH` = 4 pixels are accepted, then `req1_ready` holds 0. Releasing `out_ready` drains the FIFO in order with no loss or duplication.
- Requester 0 drops valid after 2 of 64 pixels → burst ends, no `out_last`, and a pending requester 1 is granted 2 cycles later.
- Reset asserted with 3 pixels in flight → all outputs 0 immediately. After release, no stale `out_valid` appears, and requester 0 wins the first arbitration.
- With `RGB2YUV_ARB_STATS_EN`: 10 pixels from requester 0, 7 from requester 1, and 5 stalled cycles → `stat0_pix` = 10, `stat1_pix` = 7, `stat_stall` = 5.
